// File: rtl/capture_frame_receiver.sv
// Purpose: rebuilds 128-bit capture words from the serializer's 0xA5-framed, LSB-first byte stream; drops 0x59 filler and 0x5B init words. Optional ErrCount port under RX_ERR_COUNT_EN.
// Latency: WordValid/FillerSeen/InitSeen one InCLK after the 16th data byte; SyncErr one InCLK after the bad header or expiring idle cycle.
// Backpressure: none -- every DataValid byte is consumed and downstream must accept every WordValid pulse.
module capture_frame_receiver #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic             InCLK,
    input  logic             nRst,
    input  logic [7:0]       DataIn,
    input  logic             DataValid,
    output logic [127:0]     WordOut,
    output logic             WordValid,
    output logic             FillerSeen,
    output logic             InitSeen,
    output logic             SyncErr,
    output logic             Locked,
    output logic [CNT_W-1:0] WordCount
`ifdef RX_ERR_COUNT_EN
    ,
    output logic [7:0]       ErrCount
`endif
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] FILL_BYTE = 8'h59;
    localparam logic [7:0] INIT_BYTE = 8'h5B;

    // Idle timer only has to reach TIMEOUT-1; expiry is detected on the
    // idle cycle that would take it to TIMEOUT.
    localparam int               TMR_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit               TMR_EN   = (TIMEOUT > 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        S_HUNT        = 2'd0,
        S_COLLECT     = 2'd1,
        S_EXPECT_SYNC = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       idx;
    logic [TMR_W-1:0] tmr;
    // Bytes 0..14 of the frame in progress; byte 15 is taken straight from
    // DataIn so the word can be classified on the cycle it completes.
    logic [119:0]     shift_q;

    logic [127:0]     frame_word;
    logic             in_frame;
    logic             last_byte;
    logic             is_filler;
    logic             is_init;
    logic             bad_hdr;
    logic             timeout_hit;
    logic             err_event;

    // Word classification and framing-error detection for the current cycle.
    always_comb begin
        frame_word  = {DataIn, shift_q};
        in_frame    = (state == S_COLLECT) || (state == S_EXPECT_SYNC);
        last_byte   = (state == S_COLLECT) && DataValid && (idx == 4'd15);
        is_filler   = (frame_word == {16{FILL_BYTE}});
        is_init     = (frame_word == {16{INIT_BYTE}});
        bad_hdr     = (state == S_EXPECT_SYNC) && DataValid && (DataIn != SYNC_BYTE);
        // An arriving byte always beats expiry: DataValid high masks the hit.
        timeout_hit = TMR_EN && in_frame && !DataValid && (tmr == TMR_LAST);
        err_event   = bad_hdr || timeout_hit;
    end

    // Framing FSM with registered status pulses, word output and counters.
    always_ff @(posedge InCLK or negedge nRst) begin
        if (!nRst) begin
            state      <= S_HUNT;
            idx        <= '0;
            tmr        <= '0;
            shift_q    <= '0;
            WordOut    <= '0;
            WordCount  <= '0;
            WordValid  <= 1'b0;
            FillerSeen <= 1'b0;
            InitSeen   <= 1'b0;
            SyncErr    <= 1'b0;
            Locked     <= 1'b0;
        end else begin
            WordValid  <= 1'b0;
            FillerSeen <= 1'b0;
            InitSeen   <= 1'b0;
            SyncErr    <= err_event;

            if (state == S_HUNT || DataValid || timeout_hit) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 1'b1;
            end

            if (timeout_hit) begin
                // Partial word is abandoned; idx restart discards it.
                state  <= S_HUNT;
                idx    <= '0;
                Locked <= 1'b0;
            end else begin
                case (state)
                    S_HUNT: begin
                        if (DataValid && DataIn == SYNC_BYTE) begin
                            state <= S_COLLECT;
                            idx   <= '0;
                        end
                    end
                    S_COLLECT: begin
                        if (DataValid) begin
                            // 0xA5 here is ordinary payload.
                            for (int k = 0; k < 15; k++) begin
                                if (idx == 4'(k)) begin
                                    shift_q[8*k +: 8] <= DataIn;
                                end
                            end
                            idx <= idx + 4'd1;
                            if (last_byte) begin
                                state <= S_EXPECT_SYNC;
                                if (is_filler) begin
                                    FillerSeen <= 1'b1;
                                end else if (is_init) begin
                                    InitSeen <= 1'b1;
                                end else begin
                                    WordValid <= 1'b1;
                                    WordOut   <= frame_word;
                                    WordCount <= WordCount + 1'b1;
                                end
                            end
                        end
                    end
                    S_EXPECT_SYNC: begin
                        if (DataValid) begin
                            if (DataIn == SYNC_BYTE) begin
                                Locked <= 1'b1;
                                state  <= S_COLLECT;
                                idx    <= '0;
                            end else begin
                                // The offending byte is consumed, not re-tried as a header.
                                Locked <= 1'b0;
                                state  <= S_HUNT;
                            end
                        end
                    end
                    default: begin
                        state  <= S_HUNT;
                        idx    <= '0;
                        Locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RX_ERR_COUNT_EN
    // Saturating count of framing errors, cleared only by reset.
    always_ff @(posedge InCLK or negedge nRst) begin
        if (!nRst) begin
            ErrCount <= '0;
        end else if (err_event && ErrCount != 8'hFF) begin
            ErrCount <= ErrCount + 8'd1;
        end
    end
`endif

endmodule

// File: doc/capture_frame_receiver.md
Name: capture_frame_receiver

Overview:
- Receive-side counterpart of the capture-output serializer: consumes the byte stream that serializer emits (0xA5 sync byte, then 16 data bytes, LSB-first) and reassembles 128-bit capture words.
- Sits behind the loopback/bridge byte port (second FPGA or self-test path); delivers words to the capture memory writer.
- Recognises and drops the serializer's idle patterns: all-0x59 filler words and all-0x5B init words.

Parameters:
- TIMEOUT, 1024, InCLK cycles allowed between accepted bytes inside a frame before abort; 0 disables the timeout.
- CNT_W, 11, width of WordCount; matches the serializer's NumIn width.

Ports:
- InCLK  input  1  system clock; all logic on rising edge.
- nRst  input  1  asynchronous active-low reset.
- DataIn  input  8  received byte.
- DataValid  input  1  DataIn is valid this cycle; one byte accepted per cycle it is high.
- WordOut  output  128  assembled word; byte k of the frame is placed at bits [8k+7:8k].
- WordValid  output  1  one-cycle pulse; WordOut holds a new data word.
- FillerSeen  output  1  one-cycle pulse; an all-0x59 word was received and dropped.
- InitSeen  output  1  one-cycle pulse; an all-0x5B word was received and dropped.
- SyncErr  output  1  one-cycle pulse on a framing error (bad header or timeout).
- Locked  output  1  high while the receiver is aligned to frame boundaries.
- WordCount  output  CNT_W  number of data words delivered since reset; wraps at 2^CNT_W.

Behaviour:
- Reset (nRst low, asynchronous): state=HUNT, byte index=0, timeout counter=0, WordOut=0, WordCount=0. WordValid, FillerSeen, InitSeen, SyncErr and Locked are all 0. Reset mid-frame discards the partial word.
- HUNT: waits for DataValid with DataIn==0xA5, then goes to COLLECT with index=0. All other bytes are ignored silently, with no SyncErr. Locked=0.
- COLLECT: each accepted byte is written to shift slot [index]; index increments.
  - On the 16th byte (index==15), the completed word is classified in the same cycle.
  - Outputs are registered and rise the next cycle, so latency from the last data byte to the pulse is 1 clock.
  - Classification: all bytes 0x59 gives FillerSeen. All bytes 0x5B gives InitSeen. Anything else gives WordValid, WordOut update and WordCount+1.
  - WordOut changes only on WordValid.
  - After the 16th byte, state goes to EXPECT_SYNC.
- EXPECT_SYNC: next accepted byte==0xA5 sets Locked=1 and goes to COLLECT with index=0. Any other byte pulses SyncErr, clears Locked and goes to HUNT; that byte is not re-examined as a header.
- Locked stays 1 through COLLECT/EXPECT_SYNC once set; it is cleared on SyncErr, timeout or reset.
- Timeout: applies in COLLECT and EXPECT_SYNC only.
  - The counter increments each cycle DataValid is low and clears on any accepted byte.
  - Reaching TIMEOUT pulses SyncErr, clears Locked, discards the partial word and goes to HUNT.
  - If a byte arrives on the same cycle the counter would expire, the byte wins and no timeout occurs.
- A 0xA5 byte inside COLLECT is data, not a header.
- No backpressure; downstream must accept every WordValid pulse.
- At most one of WordValid/FillerSeen/InitSeen/SyncErr is high in any cycle.

Optional Feature:
- Macro RX_ERR_COUNT_EN.
- Defined: adds output port ErrCount (8 bits), reset 0. It increments on every SyncErr pulse and saturates at 0xFF; it clears only on reset.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then bytes A5,00,01,...,0F,A5 -> one WordValid with WordOut=0x0F0E...0100 (byte 0 in [7:0]), WordCount=1, Locked=1 after the second A5.
- Bytes A5 + 16×0x59, then A5 + 16×0x5B -> FillerSeen pulse then InitSeen pulse; no WordValid; WordCount stays 0.
- Locked stream where the header position carries 0x3C -> SyncErr pulse, Locked=0. A following A5 + 16 bytes of 0x11 -> WordValid with WordOut=0x1111...11.
- TIMEOUT=8: A5 + 5 bytes, then DataValid low 8 cycles -> SyncErr pulse, partial discarded. A fresh frame is received correctly afterwards.
- Back-to-back frames with DataValid high every cycle for 3 frames -> 3 WordValid pulses 17 cycles apart, WordCount=3.
- nRst asserted after byte 7 of a frame -> all outputs 0 immediately; WordCount=0; next complete frame decodes. With RX_ERR_COUNT_EN, 300 bad headers -> ErrCount=0xFF.
